// File: rtl/bsg_link_pkt_pkg.sv
// Shared types and header field positions for the link packet receiver.
package bsg_link_pkt_pkg;

   typedef enum logic [1:0] {
      HDR = 2'd0,
      PAY = 2'd1,
      TRL = 2'd2
   } state_e;

   localparam int MAGIC_MSB = 63;
   localparam int MAGIC_LSB = 56;
   localparam int LEN_MSB   = 55;
   localparam int LEN_LSB   = 48;
   localparam int TAG_MSB   = 47;
   localparam int TAG_LSB   = 0;
   localparam int LEN_W     = 8;
   localparam int TAG_W     = 48;

endpackage

// File: rtl/bsg_link_pkt_outreg.sv
// One-entry valid/ready output register carrying payload word, framing flags and tag.
module bsg_link_pkt_outreg
   import bsg_link_pkt_pkg::*;
#(
   parameter int WIDTH_P = 64
) (
   input  logic               core_clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic [WIDTH_P-1:0] data_i,
   input  logic               sop_i,
   input  logic               eop_i,
   input  logic [TAG_W-1:0]   tag_i,
   input  logic               ready_i,
   output logic               valid_o,
   output logic [WIDTH_P-1:0] data_o,
   output logic               sop_o,
   output logic               eop_o,
   output logic [TAG_W-1:0]   tag_o
);

   // The caller only loads when the slot is empty or being drained this cycle.
   always_ff @(posedge core_clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_o <= 1'b0;
         data_o  <= '0;
         sop_o   <= 1'b0;
         eop_o   <= 1'b0;
         tag_o   <= '0;
      end else if (load_i) begin
         valid_o <= 1'b1;
         data_o  <= data_i;
         sop_o   <= sop_i;
         eop_o   <= eop_i;
         tag_o   <= tag_i;
      end else if (ready_i) begin
         valid_o <= 1'b0;
      end
   end

endmodule

// File: rtl/bsg_link_pkt_rx.sv
// Framed packet receiver: header/payload/trailer parsing, XOR check, statistics.
//  state | meaning
//  HDR   | waiting for a header word; bad headers are dropped and counted
//  PAY   | forwarding payload words, remaining counts down to the eop word
//  TRL   | next word is the XOR trailer; compared against the running checksum
module bsg_link_pkt_rx
   import bsg_link_pkt_pkg::*;
#(
   parameter int         WIDTH_P   = 64,
   parameter int         MAX_LEN_P = 255,
   parameter logic [7:0] MAGIC_P   = 8'hA5,
   parameter int         CNT_W_P   = 16
) (
   input  logic               core_clk,
   input  logic               rst_n,
   input  logic [WIDTH_P-1:0] link_data_i,
   input  logic               link_valid_i,
   output logic               link_yumi_o,
   output logic [WIDTH_P-1:0] out_data_o,
   output logic               out_valid_o,
   output logic               out_sop_o,
   output logic               out_eop_o,
   output logic [TAG_W-1:0]   out_tag_o,
   input  logic               out_ready_i,
   output logic               done_v_o,
   output logic               done_err_o,
   output logic [TAG_W-1:0]   done_tag_o,
   output logic [CNT_W_P-1:0] pkt_cnt_o,
   output logic [CNT_W_P-1:0] err_cnt_o
);

   state_e               state, state_n;
   logic [WIDTH_P-1:0]   csum;
   logic [LEN_W-1:0]     remaining;
   logic [TAG_W-1:0]     tag_r;
   logic                 first_r;
   logic                 take;
   logic                 hdr_ok;
   logic                 last_pay;
   logic [7:0]           hdr_magic;
   logic [LEN_W-1:0]     hdr_len;

   assign hdr_magic = link_data_i[MAGIC_MSB:MAGIC_LSB];
   assign hdr_len   = link_data_i[LEN_MSB:LEN_LSB];
   assign hdr_ok    = (hdr_magic == MAGIC_P) && (hdr_len != '0) &&
                      ({1'b0, hdr_len} <= 9'(MAX_LEN_P));
   assign last_pay  = (remaining == LEN_W'(1));

   // Only payload words are gated by the output register; header/trailer always drain.
   assign take        = (state != PAY) | ~out_valid_o | out_ready_i;
   assign link_yumi_o = link_valid_i & take;

   always_ff @(posedge core_clk or negedge rst_n) begin
      if (!rst_n) state <= HDR;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         HDR:     if (link_yumi_o && hdr_ok) state_n = PAY;
         PAY:     if (link_yumi_o && last_pay) state_n = TRL;
         TRL:     if (link_yumi_o) state_n = HDR;
         default: state_n = HDR;
      endcase
   end

   always_ff @(posedge core_clk or negedge rst_n) begin
      if (!rst_n) begin
         csum       <= '0;
         remaining  <= '0;
         tag_r      <= '0;
         first_r    <= 1'b0;
         done_v_o   <= 1'b0;
         done_err_o <= 1'b0;
         done_tag_o <= '0;
         pkt_cnt_o  <= '0;
         err_cnt_o  <= '0;
      end else begin
         done_v_o <= 1'b0;
         if (link_yumi_o) begin
            case (state)
               HDR: begin
                  if (hdr_ok) begin
                     tag_r     <= link_data_i[TAG_MSB:TAG_LSB];
                     remaining <= hdr_len;
                     csum      <= link_data_i;
                     first_r   <= 1'b1;
                  end else if (err_cnt_o != '1) begin
                     err_cnt_o <= err_cnt_o + CNT_W_P'(1);
                  end
               end
               PAY: begin
                  csum      <= csum ^ link_data_i;
                  remaining <= remaining - LEN_W'(1);
                  first_r   <= 1'b0;
               end
               TRL: begin
                  done_v_o   <= 1'b1;
                  done_err_o <= (link_data_i != csum);
                  done_tag_o <= tag_r;
                  if (link_data_i != csum) begin
                     if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + CNT_W_P'(1);
                  end else if (pkt_cnt_o != '1) begin
                     pkt_cnt_o <= pkt_cnt_o + CNT_W_P'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   bsg_link_pkt_outreg #(
      .WIDTH_P (WIDTH_P)
   ) u_outreg (
      .core_clk (core_clk),
      .rst_n    (rst_n),
      .load_i   (link_yumi_o && (state == PAY)),
      .data_i   (link_data_i),
      .sop_i    (first_r),
      .eop_i    (last_pay),
      .tag_i    (tag_r),
      .ready_i  (out_ready_i),
      .valid_o  (out_valid_o),
      .data_o   (out_data_o),
      .sop_o    (out_sop_o),
      .eop_o    (out_eop_o),
      .tag_o    (out_tag_o)
   );

endmodule

// File: tb/tb_bsg_link_pkt_rx.sv
// Scoreboard bench for bsg_link_pkt_rx: packet-level reference model, randomized traffic.
module tb_bsg_link_pkt_rx;

   logic        core_clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] link_data = '0;
   logic        link_valid = 1'b0;
   logic        link_yumi;
   logic [63:0] out_data;
   logic        out_valid, out_sop, out_eop;
   logic [47:0] out_tag;
   logic        out_ready = 1'b0;
   logic        done_v, done_err;
   logic [47:0] done_tag;
   logic [15:0] pkt_cnt, err_cnt;

   bsg_link_pkt_rx dut (
      .core_clk     (core_clk),
      .rst_n        (rst_n),
      .link_data_i  (link_data),
      .link_valid_i (link_valid),
      .link_yumi_o  (link_yumi),
      .out_data_o   (out_data),
      .out_valid_o  (out_valid),
      .out_sop_o    (out_sop),
      .out_eop_o    (out_eop),
      .out_tag_o    (out_tag),
      .out_ready_i  (out_ready),
      .done_v_o     (done_v),
      .done_err_o   (done_err),
      .done_tag_o   (done_tag),
      .pkt_cnt_o    (pkt_cnt),
      .err_cnt_o    (err_cnt)
   );

   always #5 core_clk = ~core_clk;

   typedef struct packed {
      logic [63:0] data;
      logic        sop;
      logic        eop;
      logic [47:0] tag;
   } out_t;

   typedef struct packed {
      logic        err;
      logic [47:0] tag;
   } done_t;

   out_t        exp_out[$];
   done_t       exp_done[$];
   logic [63:0] pay_q[$];
   out_t        e_o;
   done_t       e_d;
   int          tests = 0;
   int          fails = 0;
   int          m_pkt = 0;
   int          m_err = 0;
   int          cyc = 0;
   int          rdy_mode = 1;
   bit          t5_arm = 1'b0;
   int          t5_sop = -1;
   int          t5_eop = -1;
   int          t5_eops = 0;
   logic [63:0] snap_data;
   logic        snap_sop, snap_eop;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   always @(posedge core_clk) cyc <= cyc + 1;

   always @(posedge core_clk) begin
      #1;
      case (rdy_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: everything observed here is compared against the queued expectations.
   always @(negedge core_clk) begin
      if (rst_n) begin
         if (link_yumi) check("yumi_implies_valid", 64'(link_valid), 64'(1));
         if (out_valid && out_ready) begin
            if (exp_out.size() == 0) begin
               tests++; fails++;
               $display("FAIL out_unexpected: got %h expected no word", out_data);
            end else begin
               e_o = exp_out.pop_front();
               check("out_data", out_data, e_o.data);
               check("out_sop", 64'(out_sop), 64'(e_o.sop));
               check("out_eop", 64'(out_eop), 64'(e_o.eop));
               check("out_tag", 64'(out_tag), 64'(e_o.tag));
            end
            if (t5_arm && out_sop && t5_sop < 0) t5_sop = cyc;
            if (t5_arm && out_eop) begin
               t5_eops++;
               t5_eop = cyc;
            end
         end
         if (done_v) begin
            if (exp_done.size() == 0) begin
               tests++; fails++;
               $display("FAIL done_unexpected: got tag %h expected no done", done_tag);
            end else begin
               e_d = exp_done.pop_front();
               check("done_err", 64'(done_err), 64'(e_d.err));
               check("done_tag", 64'(done_tag), 64'(e_d.tag));
            end
         end
      end
   end

   task automatic send_word(input logic [63:0] w, output int waited);
      int n = 0;
      link_data  = w;
      link_valid = 1'b1;
      @(negedge core_clk);
      while (!link_yumi && n < 2000) begin
         @(negedge core_clk);
         n++;
      end
      if (!link_yumi) begin
         tests++; fails++;
         $display("FAIL link_yumi_timeout: got no yumi expected yumi within 2000 cycles");
      end
      waited = n;
      @(posedge core_clk);
      #1;
      link_valid = 1'b0;
   endtask

   task automatic gap(input bit en);
      if (en && $urandom_range(0, 3) == 0) begin
         repeat ($urandom_range(1, 3)) @(posedge core_clk);
         #1;
      end
   endtask

   // Reference: a packet is header + payload + XOR trailer; output words and done status follow.
   task automatic send_pkt(input logic [47:0] tag, input logic [63:0] tmask, input bit gaps);
      int          len = pay_q.size();
      int          wt;
      logic [63:0] hdr, csum;
      hdr  = {8'hA5, 8'(len), tag};
      csum = hdr;
      for (int i = 0; i < len; i++) begin
         csum = csum ^ pay_q[i];
         exp_out.push_back('{data: pay_q[i], sop: (i == 0), eop: (i == len - 1), tag: tag});
      end
      exp_done.push_back('{err: (tmask != 0), tag: tag});
      if (tmask != 0) m_err++;
      else            m_pkt++;
      send_word(hdr, wt);
      check("hdr_no_stall", 64'(wt), 64'(0));
      gap(gaps);
      for (int i = 0; i < len; i++) begin
         send_word(pay_q[i], wt);
         gap(gaps);
      end
      send_word(csum ^ tmask, wt);
      check("trl_no_stall", 64'(wt), 64'(0));
      gap(gaps);
   endtask

   task automatic send_junk(input logic [63:0] w);
      int wt;
      m_err++;
      send_word(w, wt);
      check("junk_no_stall", 64'(wt), 64'(0));
   endtask

   task automatic rand_payload(input int len);
      pay_q.delete();
      for (int i = 0; i < len; i++) pay_q.push_back({$urandom, $urandom});
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((exp_out.size() != 0 || exp_done.size() != 0) && n < 5000) begin
         @(negedge core_clk);
         n++;
      end
      if (exp_out.size() != 0 || exp_done.size() != 0) begin
         tests++; fails++;
         $display("FAIL %s_drain: got %0d words %0d dones pending expected 0", name,
                  exp_out.size(), exp_done.size());
         exp_out.delete();
         exp_done.delete();
      end
      repeat (2) @(negedge core_clk);
      check({name, "_pkt_cnt"}, 64'(pkt_cnt), 64'(m_pkt));
      check({name, "_err_cnt"}, 64'(err_cnt), 64'(m_err));
      @(posedge core_clk);
      #1;
   endtask

   task automatic hold_check();
      int n = 0;
      @(negedge core_clk);
      while (!out_valid && n < 50) begin
         @(negedge core_clk);
         n++;
      end
      check("t4_saw_valid", 64'(out_valid), 64'(1));
      rdy_mode = 0;
      @(negedge core_clk);
      snap_data = out_data;
      snap_sop  = out_sop;
      snap_eop  = out_eop;
      repeat (10) begin
         @(negedge core_clk);
         check("t4_yumi_low", 64'(link_yumi), 64'(0));
         check("t4_valid_held", 64'(out_valid), 64'(1));
         check("t4_data_held", out_data, snap_data);
         check("t4_sop_held", 64'(out_sop), 64'(snap_sop));
         check("t4_eop_held", 64'(out_eop), 64'(snap_eop));
      end
      rdy_mode = 1;
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_out_valid"}, 64'(out_valid), 64'(0));
      check({name, "_out_data"}, out_data, 64'(0));
      check({name, "_out_sop"}, 64'(out_sop), 64'(0));
      check({name, "_out_eop"}, 64'(out_eop), 64'(0));
      check({name, "_out_tag"}, 64'(out_tag), 64'(0));
      check({name, "_done_v"}, 64'(done_v), 64'(0));
      check({name, "_done_err"}, 64'(done_err), 64'(0));
      check({name, "_done_tag"}, 64'(done_tag), 64'(0));
      check({name, "_pkt_cnt"}, 64'(pkt_cnt), 64'(0));
      check({name, "_err_cnt"}, 64'(err_cnt), 64'(0));
      check({name, "_yumi"}, 64'(link_yumi), 64'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          wt;
      int          len;
      logic [63:0] w, tm;

      repeat (3) @(posedge core_clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;
      @(posedge core_clk);
      #1;

      // 1: basic good packet
      pay_q = '{64'd1, 64'd2, 64'd3};
      send_pkt(48'h1234, 64'h0, 1'b0);
      drain("t1");

      // 2: same packet, trailer corrupted
      pay_q = '{64'd1, 64'd2, 64'd3};
      send_pkt(48'h1234, 64'h1, 1'b0);
      drain("t2");

      // 3: bad magic, zero length, then a len=1 packet
      send_junk(64'h5A5A_5A5A_5A5A_5A5A);
      send_junk({8'hA5, 8'h00, 48'h0000_0000_BEEF});
      pay_q = '{64'hDEAD_BEEF_0123_4567};
      send_pkt(48'h0000_0000_0777, 64'h0, 1'b0);
      drain("t3");

      // 4: sink stalls mid-payload
      rand_payload(8);
      fork
         send_pkt(48'hABCD_0000_0004, 64'h0, 1'b0);
         hold_check();
      join
      drain("t4");

      // 5: two back-to-back maximum-length packets at full rate
      t5_arm = 1'b1;
      rand_payload(255);
      send_pkt(48'h0000_0000_0055, 64'h0, 1'b0);
      rand_payload(255);
      send_pkt(48'h0000_0000_0056, 64'h0, 1'b0);
      drain("t5");
      t5_arm = 1'b0;
      check("t5_eops", 64'(t5_eops), 64'(2));
      check("t5_span", 64'(t5_eop - t5_sop), 64'(511));

      // 6: asynchronous reset in PAY drops the packet
      rdy_mode = 0;
      @(posedge core_clk);
      #1;
      send_word({8'hA5, 8'h04, 48'h0000_0000_0666}, wt);
      send_word(64'h1111_2222_3333_4444, wt);
      link_data  = 64'h5555_6666_7777_8888;
      link_valid = 1'b1;
      @(negedge core_clk);
      check("t6_yumi_blocked", 64'(link_yumi), 64'(0));
      check("t6_out_loaded", 64'(out_valid), 64'(1));
      link_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("t6_rst");
      m_pkt = 0;
      m_err = 0;
      exp_out.delete();
      exp_done.delete();
      @(posedge core_clk);
      #1;
      rst_n = 1'b1;
      rdy_mode = 1;
      pay_q = '{64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0002};
      send_pkt(48'h0000_0000_0667, 64'h0, 1'b0);
      drain("t6");

      // Randomized traffic with gaps, junk and random back-pressure
      rdy_mode = 2;
      for (int p = 0; p < 40; p++) begin
         if ($urandom_range(0, 5) == 0) begin
            w = {$urandom, $urandom};
            if (w[63:56] == 8'hA5) w[55:48] = 8'h00;
            send_junk(w);
         end
         len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 255)) : int'($urandom_range(1, 12));
         rand_payload(len);
         tm = ($urandom_range(0, 3) == 0) ? ({$urandom, $urandom} | 64'h1) : 64'h0;
         send_pkt({$urandom, 16'($urandom)}, tm, 1'b1);
         if (p % 10 == 9) drain("rnd");
      end
      drain("rnd_end");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
